// File: rtl/fpaddsub_norm_shift_seq.sv
// Iterative left-shift normalizer for the FP add/sub datapath.
// It shifts the raw sum mantissa left by up to STEP bits per cycle. It stops
// when the MSB is 1 or the exponent reaches 0. The exponent is decremented
// by the same amount.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          upstream handshake (ready only in IDLE)
//   in_mant[MW], in_exp[EW]    unnormalized mantissa and its exponent
//   out_valid/out_ready        downstream handshake
//   out_mant, out_exp          normalized mantissa and adjusted exponent
//   out_shift[SW]              total left shift applied
//   out_zero                   input mantissa was zero
//   out_denorm                 nonzero result whose MSB is 0 (exponent exhausted)
module fpaddsub_norm_shift_seq #(
  parameter int unsigned MW   = 24,
  parameter int unsigned EW   = 8,
  parameter int unsigned STEP = 3,
  parameter int unsigned SW   = $clog2(MW) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [MW-1:0] in_mant,
  input  logic [EW-1:0] in_exp,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [MW-1:0] out_mant,
  output logic [EW-1:0] out_exp,
  output logic [SW-1:0] out_shift,
  output logic          out_zero,
  output logic          out_denorm
);

  localparam int unsigned KW = $clog2(STEP + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state;
  logic [MW-1:0] mant_q;
  logic [EW-1:0] exp_q;
  logic [SW-1:0] shift_q;

  logic [KW-1:0] lz;
  logic          lz_found;
  logic [EW-1:0] lz_e;
  logic [EW-1:0] k_e;
  logic [MW-1:0] nmant;
  logic [EW-1:0] nexp;
  logic [SW-1:0] nshift;
  logic          done_c;

  // Leading zeros of the working mantissa, counted only over the top STEP bits.
  always_comb begin
    lz       = '0;
    lz_found = 1'b0;
    for (int i = 0; i < int'(STEP); i++) begin
      if (!lz_found) begin
        if (mant_q[MW-1-i]) lz_found = 1'b1;
        else                lz = lz + KW'(1);
      end
    end
  end

  // One shift step: the shift is limited by the exponent so it never underflows.
  always_comb begin
    lz_e   = EW'(lz);
    k_e    = (lz_e < exp_q) ? lz_e : exp_q;
    nmant  = mant_q << k_e;
    nexp   = exp_q - k_e;
    nshift = shift_q + SW'(k_e);
    done_c = (k_e < EW'(STEP)) || nmant[MW-1] || (nexp == '0);
  end

  // Control and registered outputs. The out_* registers load only when DONE is entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_mant   <= '0;
      out_exp    <= '0;
      out_shift  <= '0;
      out_zero   <= 1'b0;
      out_denorm <= 1'b0;
      mant_q     <= '0;
      exp_q      <= '0;
      shift_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            shift_q  <= '0;
            if (in_mant == '0) begin
              state      <= DONE;
              mant_q     <= '0;
              exp_q      <= '0;
              out_valid  <= 1'b1;
              out_mant   <= '0;
              out_exp    <= '0;
              out_shift  <= '0;
              out_zero   <= 1'b1;
              out_denorm <= 1'b0;
            end else begin
              state  <= SHIFT;
              mant_q <= in_mant;
              exp_q  <= in_exp;
            end
          end
        end
        SHIFT: begin
          mant_q  <= nmant;
          exp_q   <= nexp;
          shift_q <= nshift;
          if (done_c) begin
            state      <= DONE;
            out_valid  <= 1'b1;
            out_mant   <= nmant;
            out_exp    <= nexp;
            out_shift  <= nshift;
            out_zero   <= 1'b0;
            out_denorm <= (nmant != '0) && !nmant[MW-1];
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpaddsub_norm_shift_seq.sv
// Directed bench for the iterative normalizer. It applies a table of
// vectors and then hand-written backpressure and reset sequences.
module tb_fpaddsub_norm_shift_seq;

  localparam int unsigned MW = 24;
  localparam int unsigned EW = 8;
  localparam int unsigned SW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] in_mant;
  logic [EW-1:0] in_exp;
  logic          out_valid;
  logic          out_ready;
  logic [MW-1:0] out_mant;
  logic [EW-1:0] out_exp;
  logic [SW-1:0] out_shift;
  logic          out_zero;
  logic          out_denorm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpaddsub_norm_shift_seq #(.MW(MW), .EW(EW), .STEP(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mant(in_mant), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant),
    .out_exp(out_exp), .out_shift(out_shift), .out_zero(out_zero),
    .out_denorm(out_denorm)
  );

  typedef struct {
    logic [MW-1:0] mant;
    logic [EW-1:0] exp;
    int            lat;
    logic [MW-1:0] omant;
    logic [EW-1:0] oexp;
    logic [SW-1:0] oshift;
    logic          zero;
    logic          denorm;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand. The caller is positioned #1 after an edge with the block idle.
  task automatic accept(input logic [MW-1:0] m, input logic [EW-1:0] e);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_mant  = m;
    in_exp   = e;
    tick();
    in_valid = 1'b0;
  endtask

  // Wait for out_valid and return the cycle index c_n at which it was seen.
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 60) begin
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      tick();
      cyc++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    accept(v.mant, v.exp);
    wait_valid(cyc);
    $display("vector %0d: mant=%06h exp=%0d valid at c%0d", idx, v.mant, v.exp, cyc);
    chk("latency",    32'(cyc),        32'(v.lat));
    chk("out_valid",  32'(out_valid),  32'd1);
    chk("out_mant",   32'(out_mant),   32'(v.omant));
    chk("out_exp",    32'(out_exp),    32'(v.oexp));
    chk("out_shift",  32'(out_shift),  32'(v.oshift));
    chk("out_zero",   32'(out_zero),   32'(v.zero));
    chk("out_denorm", 32'(out_denorm), 32'(v.denorm));
    tick();  // out_ready is high, so the handshake completes here
    chk("out_valid_after_hs", 32'(out_valid), 32'd0);
    chk("in_ready_after_hs",  32'(in_ready),  32'd1);
  endtask

  initial begin
    int cyc;
    logic seen_valid;

    //           mant          exp   lat omant         oexp  osh  z  d
    vecs[0] = '{24'h800000,  8'd10,  2, 24'h800000,  8'd10,  6'd0, 1'b0, 1'b0};
    vecs[1] = '{24'h040000,  8'd20,  3, 24'h800000,  8'd15,  6'd5, 1'b0, 1'b0};
    vecs[2] = '{24'h000001,  8'd100, 9, 24'h800000,  8'd77, 6'd23, 1'b0, 1'b0};
    vecs[3] = '{24'h010000,  8'd2,   2, 24'h040000,  8'd0,   6'd2, 1'b0, 1'b1};
    vecs[4] = '{24'h400000,  8'd5,   2, 24'h800000,  8'd4,   6'd1, 1'b0, 1'b0};
    vecs[5] = '{24'h100000,  8'd9,   2, 24'h800000,  8'd6,   6'd3, 1'b0, 1'b0};
    vecs[6] = '{24'h000001,  8'd0,   2, 24'h000001,  8'd0,   6'd0, 1'b0, 1'b1};
    vecs[7] = '{24'h080000,  8'd3,   2, 24'h400000,  8'd0,   6'd3, 1'b0, 1'b1};
    vecs[8] = '{24'h000001,  8'd10,  5, 24'h000400,  8'd0,  6'd10, 1'b0, 1'b1};
    vecs[9] = '{24'h000fff,  8'd200, 5, 24'hfff000,  8'd188, 6'd12, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mant   = '0;
    in_exp    = '0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready",   32'(in_ready),   32'd1);
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_out_mant",   32'(out_mant),   32'd0);
    chk("rst_out_exp",    32'(out_exp),    32'd0);
    chk("rst_out_shift",  32'(out_shift),  32'd0);
    chk("rst_out_zero",   32'(out_zero),   32'd0);
    chk("rst_out_denorm", 32'(out_denorm), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Zero operand under backpressure. A new in_valid while busy must be ignored.
    out_ready = 1'b0;
    accept(24'h000000, 8'd55);
    chk("zero_valid_c1", 32'(out_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_mant  = 24'h800000;
      in_exp   = 8'd9;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready",  32'(in_ready),  32'd0);
      chk("bp_out_zero",  32'(out_zero),  32'd1);
      chk("bp_out_exp",   32'(out_exp),   32'd0);
      chk("bp_out_mant",  32'(out_mant),  32'd0);
      chk("bp_out_shift", 32'(out_shift), 32'd0);
      tick();
    end
    in_valid  = 1'b0;
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready),  32'd1);
    chk("bp_zero_kept",     32'(out_zero),  32'd1);

    // Reset in the middle of a long shift: no result may appear.
    accept(24'h000001, 8'd100);  // now in c1
    seen_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      seen_valid |= out_valid;
      tick();
    end
    seen_valid |= out_valid;      // now in c3
    rst_n = 1'b0;
    tick();
    chk("midrst_no_valid", 32'(seen_valid), 32'd0);
    chk("midrst_valid",    32'(out_valid),  32'd0);
    chk("midrst_in_ready", 32'(in_ready),   32'd1);
    chk("midrst_mant",     32'(out_mant),   32'd0);
    chk("midrst_exp",      32'(out_exp),    32'd0);
    chk("midrst_shift",    32'(out_shift),  32'd0);
    chk("midrst_zero",     32'(out_zero),   32'd0);
    chk("midrst_denorm",   32'(out_denorm), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("postrst_valid", 32'(out_valid), 32'd0);
    run_vec(vecs[0], 0);

    // Reset while held in DONE under backpressure.
    out_ready = 1'b0;
    accept(24'h040000, 8'd20);
    wait_valid(cyc);
    chk("done_rst_lat", 32'(cyc), 32'd3);
    rst_n = 1'b0;
    tick();
    chk("done_rst_valid", 32'(out_valid), 32'd0);
    chk("done_rst_mant",  32'(out_mant),  32'd0);
    chk("done_rst_ready", 32'(in_ready),  32'd1);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
